// File: rtl/hazard_pipe_ctrl.sv
// Hazard detection, bubble insertion and operand-forwarding control for a 5-stage pipeline.
// Macro HAZARD_FORWARD_EN: forwarding plus counted load-use stalls; undefined means full interlock.
module hazard_pipe_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [5:0]            Op_code,
    input  logic [5:0]            Funct,
    input  logic [REG_ADDR_W-1:0] Rs,
    input  logic [REG_ADDR_W-1:0] Rt,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_RegWr,
    output logic                  ex_MemWr,
    output logic                  ex_MemtoReg,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  mem_RegWr,
    output logic                  mem_MemtoReg,
    output logic [REG_ADDR_W-1:0] mem_dst,
    output logic                  wb_RegWr,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB
);

    localparam logic [REG_ADDR_W-1:0] R0 = {REG_ADDR_W{1'b0}};

    typedef struct packed {
        logic                  reg_wr;
        logic                  mem_wr;
        logic                  mem_to_reg;
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_ADDR_W-1:0] dst;
    } dec_t;

    function automatic dec_t rr_op(input logic [REG_ADDR_W-1:0] rd);
        dec_t d;
        d        = '0;
        d.reg_wr = 1'b1;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.dst    = rd;
        return d;
    endfunction

    function automatic dec_t imm_op(input logic [REG_ADDR_W-1:0] rt, input logic is_load);
        dec_t d;
        d            = '0;
        d.reg_wr     = 1'b1;
        d.mem_to_reg = is_load;
        d.use_rs     = 1'b1;
        d.dst        = rt;
        return d;
    endfunction

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [REG_ADDR_W-1:0] rt,
                                    input logic [REG_ADDR_W-1:0] rd);
        dec_t d;
        d = '0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b100011,
                    6'b101011, 6'b000111, 6'b000010: d = rr_op(rd);
                    default:                         d = '0;
                endcase
            end
            6'b011100: begin
                case (fn)
                    6'b100000, 6'b100001: d = rr_op(rd);
                    default:              d = '0;
                endcase
            end
            6'b011111:                                        d = rr_op(rd);
            6'b001000, 6'b001001, 6'b001010,
            6'b001110, 6'b001111:                             d = imm_op(rt, 1'b0);
            6'b100011, 6'b100010, 6'b100110:                  d = imm_op(rt, 1'b1);
            6'b101011: begin
                d.mem_wr = 1'b1;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            default:                                          d = '0;
        endcase
        // Register 0 is hardwired, so a write to it is never a real producer.
        if (d.dst == R0) d.reg_wr = 1'b0;
        return d;
    endfunction

    function automatic logic src_match(input dec_t d, input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rt,
                                       input logic [REG_ADDR_W-1:0] dst);
        return (d.use_rs && (rs != R0) && (rs == dst)) ||
               (d.use_rt && (rt != R0) && (rt == dst));
    endfunction

    dec_t                  id_dec_s;
    logic                  bubble_s;
    logic [REG_ADDR_W-1:0] ex_rs_r;
    logic [REG_ADDR_W-1:0] ex_rt_r;

    assign id_dec_s = decode(Op_code, Funct, Rt, Rd);
    assign bubble_s = flush || stall || !id_valid;

`ifdef HAZARD_FORWARD_EN
    localparam logic [2:0] LAT = 3'(LOAD_LAT - 1);

    logic [2:0] stall_cnt_r;
    logic       load_use_s;

    assign load_use_s = id_valid && ex_MemtoReg && (ex_dst != R0) &&
                        src_match(id_dec_s, Rs, Rt, ex_dst);
    assign stall      = id_valid && !flush && ((stall_cnt_r != 3'd0) || load_use_s);

    // Extra load-latency bubbles beyond the detection cycle; flush discards them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 3'd0;
        end else if (flush) begin
            stall_cnt_r <= 3'd0;
        end else if (stall_cnt_r != 3'd0) begin
            stall_cnt_r <= stall_cnt_r - 3'd1;
        end else if (load_use_s) begin
            stall_cnt_r <= LAT;
        end else begin
            stall_cnt_r <= 3'd0;
        end
    end

    // Operand select for EX; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (mem_RegWr && (mem_dst == ex_rs_r))     ForwardA = 2'b10;
        else if (wb_RegWr && (wb_dst == ex_rs_r))  ForwardA = 2'b01;
        else                                       ForwardA = 2'b00;
        if (mem_RegWr && (mem_dst == ex_rt_r))     ForwardB = 2'b10;
        else if (wb_RegWr && (wb_dst == ex_rt_r))  ForwardB = 2'b01;
        else                                       ForwardB = 2'b00;
    end
`else
    logic unused_s;

    // Without forwarding, any in-flight producer of a used source holds ID.
    assign stall = id_valid && !flush &&
                   ((ex_RegWr  && src_match(id_dec_s, Rs, Rt, ex_dst))  ||
                    (mem_RegWr && src_match(id_dec_s, Rs, Rt, mem_dst)) ||
                    (wb_RegWr  && src_match(id_dec_s, Rs, Rt, wb_dst)));
    assign ForwardA = 2'b00;
    assign ForwardB = 2'b00;
    assign unused_s = ^{ex_rs_r, ex_rt_r, 3'(LOAD_LAT)};
`endif

    // Control pipeline: ID/EX takes the decoded word or a bubble, later stages shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_RegWr     <= 1'b0;
            ex_MemWr     <= 1'b0;
            ex_MemtoReg  <= 1'b0;
            ex_dst       <= R0;
            ex_rs_r      <= R0;
            ex_rt_r      <= R0;
            mem_RegWr    <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_dst      <= R0;
            wb_RegWr     <= 1'b0;
            wb_dst       <= R0;
        end else begin
            if (bubble_s) begin
                ex_RegWr    <= 1'b0;
                ex_MemWr    <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_dst      <= R0;
                ex_rs_r     <= R0;
                ex_rt_r     <= R0;
            end else begin
                ex_RegWr    <= id_dec_s.reg_wr;
                ex_MemWr    <= id_dec_s.mem_wr;
                ex_MemtoReg <= id_dec_s.mem_to_reg;
                ex_dst      <= id_dec_s.dst;
                ex_rs_r     <= Rs;
                ex_rt_r     <= Rt;
            end
            mem_RegWr    <= ex_RegWr;
            mem_MemtoReg <= ex_MemtoReg;
            mem_dst      <= ex_dst;
            wb_RegWr     <= mem_RegWr;
            wb_dst       <= mem_dst;
        end
    end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Self-checking bench for hazard_pipe_ctrl: decode vector table plus hazard/flush/reset sequences.
module tb_hazard_pipe_ctrl;

    localparam int LAT_TB = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] Op_code;
    logic [5:0] Funct;
    logic [4:0] Rs, Rt, Rd;
    logic       flush;
    logic       stall;
    logic       ex_RegWr, ex_MemWr, ex_MemtoReg;
    logic [4:0] ex_dst;
    logic       mem_RegWr, mem_MemtoReg;
    logic [4:0] mem_dst;
    logic       wb_RegWr;
    logic [4:0] wb_dst;
    logic [1:0] ForwardA, ForwardB;

    hazard_pipe_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(LAT_TB)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .Op_code(Op_code), .Funct(Funct),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .flush(flush), .stall(stall),
        .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg), .ex_dst(ex_dst),
        .mem_RegWr(mem_RegWr), .mem_MemtoReg(mem_MemtoReg), .mem_dst(mem_dst),
        .wb_RegWr(wb_RegWr), .wb_dst(wb_dst), .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       m2r;
        logic [4:0] dst;
    } ctl_t;

    typedef struct packed {
        logic       valid;
        logic       flush;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       st;
        ctl_t       ex;
        logic [3:0] fwd;
    } vec_t;

    localparam ctl_t BUB = '0;

    ctl_t exp_q[$];
    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic ctl_t wr(input logic [4:0] dst);
        ctl_t c;
        c = '0; c.rw = 1'b1; c.dst = dst;
        return c;
    endfunction

    function automatic ctl_t ld(input logic [4:0] dst, input logic rw);
        ctl_t c;
        c = '0; c.rw = rw; c.m2r = 1'b1; c.dst = dst;
        return c;
    endfunction

    function automatic vec_t iv(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input ctl_t ex);
        vec_t v;
        v = '0; v.valid = 1'b1; v.op = op; v.fn = fn; v.rs = rs; v.rt = rt; v.rd = rd; v.ex = ex;
        return v;
    endfunction

    function automatic vec_t held(input vec_t v);
        vec_t h;
        h = v; h.st = 1'b1; h.ex = BUB; h.fwd = 4'b0000;
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_zero(input string name);
        chk(name, 32'({stall, ex_RegWr, ex_MemWr, ex_MemtoReg, ex_dst, mem_RegWr, mem_MemtoReg,
                       mem_dst, wb_RegWr, wb_dst, ForwardA, ForwardB}), 32'd0);
    endtask

    task automatic sb_reset();
        exp_q.delete();
        exp_q.push_back(BUB);
        exp_q.push_back(BUB);
    endtask

    // One ID cycle: check stall before the edge, then the three pipeline stages after it.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        id_valid = v.valid; flush = v.flush; Op_code = v.op; Funct = v.fn;
        Rs = v.rs; Rt = v.rt; Rd = v.rd;
        #1;
        chk({tag, " stall"}, 32'(stall), 32'(v.st));
        exp_q.push_back(v.ex);
        @(posedge clk);
        #1;
        while (exp_q.size() > 3) void'(exp_q.pop_front());
        chk({tag, " ex"}, 32'({ex_RegWr, ex_MemWr, ex_MemtoReg, ex_dst}), 32'(exp_q[2]));
        chk({tag, " mem"}, 32'({mem_RegWr, mem_MemtoReg, mem_dst}),
            32'({exp_q[1].rw, exp_q[1].m2r, exp_q[1].dst}));
        chk({tag, " wb"}, 32'({wb_RegWr, wb_dst}), 32'({exp_q[0].rw, exp_q[0].dst}));
        chk({tag, " fwd"}, 32'({ForwardA, ForwardB}), 32'(v.fwd));
    endtask

    task automatic drain();
        vec_t v;
        v = '0;
        repeat (3) step("drain", v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v, prod, cons, cons_go;
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; Op_code = 6'd0; Funct = 6'd0;
        Rs = 5'd0; Rt = 5'd0; Rd = 5'd0;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk_zero("first edge after release");
        sb_reset();

        // Decode table: sources 20/21 never written, so no vector interlocks or forwards.
        tbl.push_back(iv(OP_R, 6'b100000, 5'd20, 5'd21, 5'd1, wr(5'd1)));
        tbl.push_back(iv(OP_R, 6'b100010, 5'd20, 5'd21, 5'd2, wr(5'd2)));
        tbl.push_back(iv(OP_R, 6'b100011, 5'd20, 5'd21, 5'd3, wr(5'd3)));
        tbl.push_back(iv(OP_R, 6'b101011, 5'd20, 5'd21, 5'd4, wr(5'd4)));
        tbl.push_back(iv(OP_R, 6'b000111, 5'd20, 5'd21, 5'd5, wr(5'd5)));
        tbl.push_back(iv(OP_R, 6'b000010, 5'd20, 5'd21, 5'd6, wr(5'd6)));
        tbl.push_back(iv(OP_R, 6'b000000, 5'd20, 5'd21, 5'd17, BUB));
        tbl.push_back(iv(6'b011100, 6'b100000, 5'd20, 5'd21, 5'd7, wr(5'd7)));
        tbl.push_back(iv(6'b011100, 6'b100001, 5'd20, 5'd21, 5'd8, wr(5'd8)));
        tbl.push_back(iv(6'b011100, 6'b000010, 5'd20, 5'd21, 5'd18, BUB));
        tbl.push_back(iv(6'b011111, 6'b010101, 5'd20, 5'd21, 5'd9, wr(5'd9)));
        tbl.push_back(iv(6'b001000, 6'b000000, 5'd20, 5'd10, 5'd29, wr(5'd10)));
        tbl.push_back(iv(6'b001001, 6'b000000, 5'd20, 5'd11, 5'd29, wr(5'd11)));
        tbl.push_back(iv(6'b001010, 6'b000000, 5'd20, 5'd12, 5'd29, wr(5'd12)));
        tbl.push_back(iv(6'b001110, 6'b000000, 5'd20, 5'd13, 5'd29, wr(5'd13)));
        tbl.push_back(iv(6'b001111, 6'b000000, 5'd20, 5'd14, 5'd29, wr(5'd14)));
        tbl.push_back(iv(6'b100011, 6'b000000, 5'd20, 5'd15, 5'd29, ld(5'd15, 1'b1)));
        tbl.push_back(iv(6'b100010, 6'b000000, 5'd20, 5'd16, 5'd29, ld(5'd16, 1'b1)));
        tbl.push_back(iv(6'b100110, 6'b000000, 5'd20, 5'd19, 5'd29, ld(5'd19, 1'b1)));
        v = iv(6'b101011, 6'b000000, 5'd20, 5'd21, 5'd9, BUB); v.ex.mw = 1'b1;
        tbl.push_back(v);
        tbl.push_back(iv(6'b000010, 6'b000000, 5'd20, 5'd21, 5'd9, BUB));
        tbl.push_back(iv(OP_ADDI, 6'b000000, 5'd20, 5'd0, 5'd9, BUB));
        tbl.push_back(iv(6'b111111, 6'b100000, 5'd20, 5'd21, 5'd9, BUB));
        v = iv(OP_R, F_ADD, 5'd20, 5'd21, 5'd1, BUB); v.flush = 1'b1;
        tbl.push_back(v);
        v = iv(OP_R, F_ADD, 5'd20, 5'd21, 5'd2, BUB); v.valid = 1'b0;
        tbl.push_back(v);
        tbl.push_back(iv(OP_LW, 6'b000000, 5'd20, 5'd0, 5'd9, ld(5'd0, 1'b0)));
        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);
        drain();

        // add $5,$1,$1 then sub $6,$5,$5
        step("s1 add", iv(OP_R, F_ADD, 5'd1, 5'd1, 5'd5, wr(5'd5)));
        v = iv(OP_R, F_SUB, 5'd5, 5'd5, 5'd6, wr(5'd6));
`ifdef HAZARD_FORWARD_EN
        v.fwd = 4'b1010;
`else
        repeat (3) step("s1 sub held", held(v));
`endif
        step("s1 sub", v);
        drain();

        // addi $0,$1,5 then a consumer of $0
        step("s2 addi0", iv(OP_ADDI, 6'b000101, 5'd1, 5'd0, 5'd0, BUB));
        step("s2 use0", iv(OP_R, F_ADD, 5'd0, 5'd0, 5'd9, wr(5'd9)));
        drain();

`ifdef HAZARD_FORWARD_EN
        prod    = iv(OP_LW, 6'b000000, 5'd20, 5'd2, 5'd0, ld(5'd2, 1'b1));
        cons    = iv(OP_R, F_ADD, 5'd2, 5'd4, 5'd3, wr(5'd3));
        cons_go = cons;
        cons_go.fwd = (LAT_TB == 1) ? 4'b0100 : 4'b0000;
`else
        prod    = iv(OP_R, F_ADD, 5'd1, 5'd2, 5'd7, wr(5'd7));
        cons    = iv(OP_R, F_ADD, 5'd7, 5'd7, 5'd8, wr(5'd8));
        cons_go = cons;
`endif

        // Hazard and flush in the same cycle
        step("s3 prod", prod);
        v = cons; v.flush = 1'b1; v.ex = BUB;
        step("s3 flush", v);
`ifdef HAZARD_FORWARD_EN
        v = cons; v.fwd = 4'b0100;
        step("s3 after flush", v);
`else
        repeat (2) step("s3 held", held(cons));
        step("s3 after flush", cons);
`endif
        drain();

        // Reset pulsed in the second stall cycle
        step("s5 prod", prod);
        step("s5 stall1", held(cons));
        @(negedge clk);
        #1 chk("s5 stall2 before reset", 32'(stall), 32'd1);
        rst = 1'b1;
        #1 chk_zero("s5 reset asserted");
        @(posedge clk);
        #1 chk_zero("s5 reset held");
        @(negedge clk);
        rst = 1'b0; id_valid = 1'b0;
        @(posedge clk);
        #1 chk_zero("s5 first edge after release");
        sb_reset();
        v = cons; v.fwd = 4'b0000;
        step("s5 consumer after reset", v);
        drain();

        // Full load-use (counted) or interlock (three stages) stall
        step("s4 prod", prod);
`ifdef HAZARD_FORWARD_EN
        repeat (LAT_TB) step("s4 held", held(cons));
`else
        repeat (3) step("s4 held", held(cons));
`endif
        step("s4 release", cons_go);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_ctrl.md
HAZARD_PIPE_CTRL -- requirements
Module: hazard_pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-specifier width (register 0 hardwired zero).
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..7, meaning bubble cycles inserted for a load-use hazard.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID stage holds a valid instruction
- Op_code  in  6  ID opcode
- Funct  in  6  ID function field
- Rs, Rt, Rd  in  REG_ADDR_W each  ID register specifiers
- flush  in  1  taken branch/jump resolved; kill ID
- stall  out  1  hold PC and IF/ID
- ex_RegWr, ex_MemWr, ex_MemtoReg  out  1 each  ID/EX control
- ex_dst  out  REG_ADDR_W  ID/EX destination
- mem_RegWr, mem_MemtoReg  out  1 each  EX/MEM control
- mem_dst  out  REG_ADDR_W  EX/MEM destination
- wb_RegWr  out  1  MEM/WB write enable
- wb_dst  out  REG_ADDR_W  MEM/WB destination
- ForwardA, ForwardB  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB

Function
REQ-004 Decode SHALL be combinational on ID fields. R-type (op 000000; Funct 100000/100010/100011/101011/000111/000010) and op 011100 (Funct 100000/100001), plus op 011111: RegWr=1, dst=Rd, uses Rs,Rt. Immediates 001000/001001/001010/001110/001111: RegWr=1, dst=Rt, uses Rs. Loads 100011/100010/100110: RegWr=1, MemtoReg=1, dst=Rt, uses Rs. Store 101011: MemWr=1, uses Rs,Rt. Jump 000010: no write, no sources. Any other encoding SHALL decode as NOP.
REQ-005 Decoded RegWr SHALL be forced 0 when dst==0.
REQ-006 Each clock, ID/EX<-decoded word (or bubble); EX/MEM<-ID/EX; MEM/WB<-EX/MEM. Control output latency: one stage per cycle.
REQ-007 A bubble SHALL clear RegWr, MemWr, MemtoReg and set dst=0.
REQ-008 Load-use: if id_valid, ex_MemtoReg=1, ex_dst!=0, and ex_dst equals a used ID source, then stall=1 and a bubble enters ID/EX.
REQ-009 A 3-bit stall counter SHALL load LAT=LOAD_LAT-1 on detection. While nonzero, stall=1, bubbles are inserted, and the counter decrements. stall SHALL deassert the cycle after the counter reaches 0.
REQ-010 flush=1 SHALL insert a bubble into ID/EX and clear the stall counter that cycle. flush SHALL take priority over a simultaneous hazard. stall SHALL be 0 in a flush cycle.
REQ-011 !id_valid SHALL be treated as a bubble and SHALL never raise stall.
REQ-012 ForwardA (ForwardB) SHALL compare the registered ID/EX Rs (Rt). Select 10 if mem_RegWr and mem_dst matches. Otherwise select 01 if wb_RegWr and wb_dst matches. Otherwise select 00. EX/MEM has priority.

Reset
REQ-013 rst=1 SHALL asynchronously clear all pipeline registers, the stall counter, and the registered Rs/Rt. All outputs SHALL read 0 while rst is asserted and on the first edge after release.
REQ-014 Reset asserted mid-stall SHALL abort the stall. No bubble count SHALL survive reset.

Configuration
REQ-015 Macro HAZARD_FORWARD_EN defined: REQ-012 forwarding and REQ-008/009 stall behaviour apply.
REQ-016 HAZARD_FORWARD_EN undefined: ForwardA/B SHALL be tied 00. stall SHALL assert (single cycle per evaluation, no counter) whenever a used ID source (nonzero) matches a RegWr destination in ID/EX, EX/MEM or MEM/WB, with a bubble inserted, until no match remains.

Verification
REQ-017 lw $2 then add $3,$2,$4 (FORWARD_EN, LOAD_LAT=1): stall=1 for exactly 1 cycle. One bubble observed at EX. Next cycle ForwardA=01.
REQ-018 add $5,$1,$1 then sub $6,$5,$5: no stall, ForwardA=ForwardB=10 when sub is in EX.
REQ-019 LOAD_LAT=3 load-use: stall high 3 consecutive cycles, 3 bubbles, then release.
REQ-020 Load-use hazard and flush=1 in the same cycle: stall=0, bubble inserted, counter 0.
REQ-021 addi $0,$1,5 followed by a consumer of $0: RegWr=0 down the pipe, no forwarding, no stall.
REQ-022 rst pulsed during the 2nd cycle of a LOAD_LAT=3 stall: all outputs 0 immediately. After release with HAZARD_FORWARD_EN undefined, add $7 then use $7: stall for 3 cycles.
